mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Single-port memory responder that serves both the instruction-fetch port and the memory-stage port of the MIPS32 pipeline. It serializes their requests onto one synchronous byte-laned RAM. It returns read data and a one-cycle completion pulse per request, and raises a pipeline stall while any request is outstanding. It sits between the Mips core and the Ram, replacing the purely combinational routing path with an arbitrated, handshaked one.

## Interface
- No parameters; widths fixed (32-bit address/data, 4 byte lanes).
- clock  in  1  rising-edge clock
- reset  in  1  reset, asynchronous, active-high
- if_mc_en  in  1  fetch request; held with addr until mc_if_valid
- if_mc_addr  in  32  fetch byte address
- mc_if_data  out  32  fetch read data, valid with mc_if_valid
- mc_if_valid  out  1  one-cycle fetch completion pulse
- mem_mc_en  in  1  memory-stage request; held with all fields until mc_mem_valid
- mem_mc_rw  in  1  1 = write, 0 = read
- mem_mc_addr  in  32  memory-stage byte address
- mem_mc_wdata  in  32  write data, big-endian lanes
- mem_mc_en1h, mem_mc_en1l, mem_mc_en2h, mem_mc_en2l  in  1 each  lane enables for bits 31:24, 23:16, 15:8, 7:0
- mc_mem_data  out  32  read data, valid with mc_mem_valid; disabled lanes read 0
- mc_mem_valid  out  1  one-cycle completion pulse (reads and writes)
- mc_stall  out  1  combinational: (mem_mc_en & ~mc_mem_valid) | (if_mc_en & ~mc_if_valid)
- ram_addr  out  32  registered, always word-aligned {addr[31:2],2'b00}
- ram_rw  out  1  registered, 1 = write
- ram_en  out  4  registered lane enables, [3] = 1h … [0] = 2l
- ram_wdata  out  32  registered write data
- ram_rdata  in  32  RAM read data, valid one cycle after command sampled
- mc_align_err  out  1  sticky misalignment flag (see Configuration)

## Operation
- FSM states: IDLE, CMD, WAIT.
- IDLE: at the clock edge, select a request and register the RAM command; go to CMD. With no request, stay in IDLE with ram_en = 0.
- Priority: memory stage over fetch. After a memory access completes with a fetch pending, that fetch is served before the next memory access. No starvation.
- Fetch commands: ram_rw = 0, ram_en = 4'b1111.
- CMD: RAM samples the command at the next edge; go to WAIT. ram_en drops to 0 on that edge.
- WAIT: at the edge, latch ram_rdata into the requester's data register; pulse its valid for the following cycle.
  - If the other port is pending, go to CMD with its command registered on the same edge.
  - Otherwise go to IDLE.
- A port's en is ignored on any edge where that port's valid is high, so a held request is never served twice.
- Writes: no data latch; valid still pulses; data output holds its previous value.
- Reset values: state IDLE; ram_addr, ram_wdata, mc_if_data, mc_mem_data = 0; ram_rw = 0, ram_en = 0; both valids = 0; mc_align_err = 0.
- Reset mid-access: state and ram_en clear immediately (asynchronously). A command not yet sampled by the RAM is never written. No valid pulse is issued for the aborted request.

## Timing
- Latency: request sampled at edge E0; command driven E0..E1; data captured at E2; valid high in the cycle after E2.
- Isolated access: 3 cycles request-to-valid.
- Back-to-back fetch + memory access: second valid exactly 2 cycles after the first.
- mc_stall is combinational and drops in the same cycle the last pending valid is high.

## Configuration
- MEM_ARB_ALIGN_CHECK_EN defined:
  - A fetch with addr[1:0] != 0 is misaligned.
  - A memory access with all four lanes enabled and addr[1:0] != 0 is misaligned.
  - A misaligned request issues ram_en = 0 (no RAM effect), returns data 0 with normal timing, and sets mc_align_err until reset.
- Undefined: addr[1:0] ignored, access proceeds to the aligned word, mc_align_err tied 0.

## Structure
- Shared package mem_arb_pkg holds:
  - state encoding (IDLE, CMD, WAIT)
  - lane index constants (LANE_1H = 3 … LANE_2L = 0)
  - requester-select encoding (SEL_IF, SEL_MEM)
- One sub-module, mem_arb_lanes: combinational steering of the four per-lane enables into ram_en, and zero-masking of disabled lanes on read data.

## Test plan
- Reset, then fetch at 0x00000008 with RAM word 0x20080005 -> mc_if_data = 0x20080005, valid in cycle 3, mc_stall high cycles 0–2.
- Memory write 0xDEADBEEF to 0x00000010, lanes 1111; then read -> read returns 0xDEADBEEF.
- Byte write 0xAB on lane 2l to 0x00000013 over 0x11223344 -> word reads 0x112233AB; a lane-1h-only read returns 0x11000000.
- Fetch and memory read asserted in the same cycle -> mc_mem_valid first (cycle 3), mc_if_valid cycle 5, each exactly once.
- Reset asserted during CMD of a write -> RAM word unchanged, no valid pulse, all outputs at reset values.
- With MEM_ARB_ALIGN_CHECK_EN, fetch at 0x00000006 -> ram_en stays 0, data 0, mc_align_err = 1 until reset; without the macro the word at 0x00000004 is returned.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter: FSM state encoding,
// requester-select encoding, byte-lane indices and small lane helpers.
// Lane numbering is big-endian: lane 3 (1h) carries bits 31:24 and
// lane 0 (2l) carries bits 7:0.

package mem_arb_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,   // no access in flight
        CMD  = 2'd1,   // command registered, RAM samples it at the next edge
        WAIT = 2'd2    // RAM read data arrives, captured at the next edge
    } arb_state_t;

    // Which requester the in-flight access belongs to
    typedef enum logic {
        SEL_IF  = 1'b0,
        SEL_MEM = 1'b1
    } arb_sel_t;

    // Byte lane indices into ram_en / lane vectors
    localparam int LANE_1H = 3;
    localparam int LANE_1L = 2;
    localparam int LANE_2H = 1;
    localparam int LANE_2L = 0;

    localparam logic [3:0] LANES_ALL  = 4'b1111;
    localparam logic [3:0] LANES_NONE = 4'b0000;

    // Expand a 4-bit lane vector into a 32-bit byte mask
    function automatic logic [31:0] lane_mask(input logic [3:0] lanes);
        logic [31:0] mask;
        mask = '0;
        for (int i = 0; i < 4; i++) begin
            mask[8*i +: 8] = {8{lanes[i]}};
        end
        return mask;
    endfunction

    // Force a byte address onto its containing word
    function automatic logic [31:0] word_addr(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/mem_arb_lanes.sv
// Byte-lane steering for the memory port arbiter.
// Collects the four memory-stage lane enables into a ram_en-ordered vector
// and zero-masks read data on lanes that were not part of the access.

module mem_arb_lanes
    import mem_arb_pkg::*;
(
    input  logic        en1h,
    input  logic        en1l,
    input  logic        en2h,
    input  logic        en2l,
    output logic [3:0]  lanes,
    input  logic [3:0]  read_lanes,
    input  logic [31:0] rdata,
    output logic [31:0] rdata_masked
);

    // Place each lane enable at its ram_en bit position
    always_comb begin
        lanes          = LANES_NONE;
        lanes[LANE_1H] = en1h;
        lanes[LANE_1L] = en1l;
        lanes[LANE_2H] = en2h;
        lanes[LANE_2L] = en2l;
    end

    // Lanes outside the issued access read back as zero
    always_comb begin
        rdata_masked = rdata & lane_mask(read_lanes);
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory responder shared by the instruction-fetch port and the
// memory-stage port. Requests are serialized onto one synchronous byte-laned
// RAM through a three-state FSM (IDLE -> CMD -> WAIT). The memory stage wins
// ties; a fetch that waited behind a memory access is served straight out of
// WAIT before any further memory access, so neither side starves.
//
// Handshake: a requester raises its en with stable fields and holds them until
// its valid pulses for one cycle. On any edge where a port's valid is high its
// en is ignored, so the held request is not served a second time.
//
// Optional feature macro: MEM_ARB_ALIGN_CHECK_EN. When defined, misaligned
// fetches and misaligned full-word memory accesses are issued with no lanes
// enabled, return zero with normal timing and set the sticky mc_align_err.
// When undefined, address bits 1:0 are ignored and mc_align_err is 0.

module mem_port_arbiter
    import mem_arb_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    // instruction-fetch port
    input  logic        if_mc_en,
    input  logic [31:0] if_mc_addr,
    output logic [31:0] mc_if_data,
    output logic        mc_if_valid,
    // memory-stage port
    input  logic        mem_mc_en,
    input  logic        mem_mc_rw,
    input  logic [31:0] mem_mc_addr,
    input  logic [31:0] mem_mc_wdata,
    input  logic        mem_mc_en1h,
    input  logic        mem_mc_en1l,
    input  logic        mem_mc_en2h,
    input  logic        mem_mc_en2l,
    output logic [31:0] mc_mem_data,
    output logic        mc_mem_valid,
    // pipeline stall
    output logic        mc_stall,
    // RAM side
    output logic [31:0] ram_addr,
    output logic        ram_rw,
    output logic [3:0]  ram_en,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    // status
    output logic        mc_align_err
);

    arb_state_t  state;
    arb_sel_t    sel;         // owner of the access in flight
    logic        cur_rw;      // in-flight access is a write
    logic [3:0]  cur_lanes;   // lanes actually issued; zero for a rejected access

    logic [3:0]  mem_lanes;
    logic [31:0] rdata_masked;

    logic        if_pend;
    logic        mem_pend;
    logic        if_mis;
    logic        mem_mis;

    logic        issue;       // register a new RAM command on this edge
    arb_sel_t    issue_sel;

    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        cmd_rw;
    logic [3:0]  cmd_lanes;
    logic        cmd_mis;

    mem_arb_lanes u_lanes (
        .en1h         (mem_mc_en1h),
        .en1l         (mem_mc_en1l),
        .en2h         (mem_mc_en2h),
        .en2l         (mem_mc_en2l),
        .lanes        (mem_lanes),
        .read_lanes   (cur_lanes),
        .rdata        (ram_rdata),
        .rdata_masked (rdata_masked)
    );

    // A request is live only while its completion pulse is not showing
    assign if_pend  = if_mc_en  & ~mc_if_valid;
    assign mem_pend = mem_mc_en & ~mc_mem_valid;
    assign mc_stall = if_pend | mem_pend;

`ifdef MEM_ARB_ALIGN_CHECK_EN
    // Byte and halfword memory accesses may use any offset; only full words must align
    assign if_mis  = |if_mc_addr[1:0];
    assign mem_mis = (&mem_lanes) & (|mem_mc_addr[1:0]);
`else
    assign if_mis  = 1'b0;
    assign mem_mis = 1'b0;
    logic unused_align_bits;
    assign unused_align_bits = ^{if_mc_addr[1:0], mem_mc_addr[1:0], cmd_mis};
`endif

    // Choose whether to start an access and for which requester
    always_comb begin
        issue     = 1'b0;
        issue_sel = SEL_MEM;
        case (state)
            IDLE: begin
                if (mem_pend) begin
                    issue     = 1'b1;
                    issue_sel = SEL_MEM;
                end else if (if_pend) begin
                    issue     = 1'b1;
                    issue_sel = SEL_IF;
                end
            end
            WAIT: begin
                // Hand over to the other port if it has been waiting
                if (sel == SEL_MEM && if_pend) begin
                    issue     = 1'b1;
                    issue_sel = SEL_IF;
                end else if (sel == SEL_IF && mem_pend) begin
                    issue     = 1'b1;
                    issue_sel = SEL_MEM;
                end
            end
            default: begin
                issue     = 1'b0;
                issue_sel = SEL_MEM;
            end
        endcase
    end

    // Build the RAM command for the selected requester
    always_comb begin
        if (issue_sel == SEL_MEM) begin
            cmd_addr  = word_addr(mem_mc_addr);
            cmd_rw    = mem_mc_rw;
            cmd_wdata = mem_mc_wdata;
            cmd_lanes = mem_mis ? LANES_NONE : mem_lanes;
            cmd_mis   = mem_mis;
        end else begin
            cmd_addr  = word_addr(if_mc_addr);
            cmd_rw    = 1'b0;
            cmd_wdata = '0;
            cmd_lanes = if_mis ? LANES_NONE : LANES_ALL;
            cmd_mis   = if_mis;
        end
    end

    // Arbiter FSM with registered RAM command, read data and completion pulses
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            sel          <= SEL_IF;
            cur_rw       <= 1'b0;
            cur_lanes    <= LANES_NONE;
            ram_addr     <= '0;
            ram_rw       <= 1'b0;
            ram_en       <= LANES_NONE;
            ram_wdata    <= '0;
            mc_if_data   <= '0;
            mc_mem_data  <= '0;
            mc_if_valid  <= 1'b0;
            mc_mem_valid <= 1'b0;
        end else begin
            mc_if_valid  <= 1'b0;
            mc_mem_valid <= 1'b0;

            if (issue) begin
                sel       <= issue_sel;
                cur_rw    <= cmd_rw;
                cur_lanes <= cmd_lanes;
                ram_addr  <= cmd_addr;
                ram_rw    <= cmd_rw;
                ram_en    <= cmd_lanes;
                ram_wdata <= cmd_wdata;
            end

            case (state)
                IDLE: begin
                    if (issue) begin
                        state <= CMD;
                    end else begin
                        ram_en <= LANES_NONE;
                    end
                end
                CMD: begin
                    // RAM samples the command on this edge; it must not repeat
                    ram_en <= LANES_NONE;
                    state  <= WAIT;
                end
                WAIT: begin
                    // Writes pulse valid but leave the data register untouched
                    if (sel == SEL_MEM) begin
                        mc_mem_valid <= 1'b1;
                        if (!cur_rw) begin
                            mc_mem_data <= rdata_masked;
                        end
                    end else begin
                        mc_if_valid <= 1'b1;
                        mc_if_data  <= rdata_masked;
                    end
                    state <= issue ? CMD : IDLE;
                end
                default: begin
                    ram_en <= LANES_NONE;
                    state  <= IDLE;
                end
            endcase
        end
    end

`ifdef MEM_ARB_ALIGN_CHECK_EN
    // Sticky misalignment flag, cleared only by reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mc_align_err <= 1'b0;
        end else if (issue && cmd_mis) begin
            mc_align_err <= 1'b1;
        end
    end
`else
    assign mc_align_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter. A behavioural byte-laned RAM
// sits on the RAM side; a word-array reference model predicts read data,
// completion timing, RAM command counts and the alignment flag.

`timescale 1ns/1ps

module tb_mem_port_arbiter;

`ifdef MEM_ARB_ALIGN_CHECK_EN
    localparam bit ALIGN_CHECK = 1'b1;
`else
    localparam bit ALIGN_CHECK = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    // ---------------- DUT signals ----------------
    logic        if_mc_en = 1'b0;
    logic [31:0] if_mc_addr = '0;
    logic [31:0] mc_if_data;
    logic        mc_if_valid;
    logic        mem_mc_en = 1'b0;
    logic        mem_mc_rw = 1'b0;
    logic [31:0] mem_mc_addr = '0;
    logic [31:0] mem_mc_wdata = '0;
    logic        mem_mc_en1h = 1'b0;
    logic        mem_mc_en1l = 1'b0;
    logic        mem_mc_en2h = 1'b0;
    logic        mem_mc_en2l = 1'b0;
    logic [31:0] mc_mem_data;
    logic        mc_mem_valid;
    logic        mc_stall;
    logic [31:0] ram_addr;
    logic        ram_rw;
    logic [3:0]  ram_en;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata = '0;
    logic        mc_align_err;

    mem_port_arbiter dut (
        .clock        (clock),
        .reset        (reset),
        .if_mc_en     (if_mc_en),
        .if_mc_addr   (if_mc_addr),
        .mc_if_data   (mc_if_data),
        .mc_if_valid  (mc_if_valid),
        .mem_mc_en    (mem_mc_en),
        .mem_mc_rw    (mem_mc_rw),
        .mem_mc_addr  (mem_mc_addr),
        .mem_mc_wdata (mem_mc_wdata),
        .mem_mc_en1h  (mem_mc_en1h),
        .mem_mc_en1l  (mem_mc_en1l),
        .mem_mc_en2h  (mem_mc_en2h),
        .mem_mc_en2l  (mem_mc_en2l),
        .mc_mem_data  (mc_mem_data),
        .mc_mem_valid (mc_mem_valid),
        .mc_stall     (mc_stall),
        .ram_addr     (ram_addr),
        .ram_rw       (ram_rw),
        .ram_en       (ram_en),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata),
        .mc_align_err (mc_align_err)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // ---------------- RAM environment ----------------
    logic [31:0] ram [0:255];
    int ram_cmds = 0;

    // Synchronous byte-laned RAM: read data registered one cycle after the command
    always @(posedge clock) begin
        if (|ram_en) begin
            if (ram_rw) begin
                for (int i = 0; i < 4; i++) begin
                    if (ram_en[i]) ram[ram_addr[9:2]][8*i +: 8] = ram_wdata[8*i +: 8];
                end
            end else begin
                ram_rdata <= ram[ram_addr[9:2]];
            end
        end
    end

    // Count issued commands and confirm word alignment
    always @(negedge clock) begin
        if (|ram_en) begin
            ram_cmds++;
            check("ram_addr_aligned", 32'(ram_addr[1:0]), 32'd0);
        end
    end

    // ---------------- reference model ----------------
    logic [31:0] ref_mem [0:255];
    logic [31:0] exp_if_q[$];
    logic [31:0] exp_mem_q[$];
    logic [31:0] last_mem_data = '0;
    logic        exp_align_err = 1'b0;

    function automatic logic [31:0] lane_bits(input logic [3:0] lanes);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) begin
            if (lanes[i]) m = m | (32'hFF << (8 * i));
        end
        return m;
    endfunction

    task automatic model_mem(input bit rw, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] lanes, output bit mis);
        logic [7:0]  idx;
        logic [31:0] m;
        logic [31:0] d;
        idx = addr[9:2];
        m   = lane_bits(lanes);
        mis = ALIGN_CHECK && (lanes == 4'hF) && (addr[1:0] != 2'b00);
        if (mis) exp_align_err = 1'b1;
        if (rw) begin
            if (!mis) ref_mem[idx] = (ref_mem[idx] & ~m) | (wdata & m);
            exp_mem_q.push_back(last_mem_data);
        end else begin
            d = mis ? 32'd0 : (ref_mem[idx] & m);
            last_mem_data = d;
            exp_mem_q.push_back(d);
        end
    endtask

    task automatic model_fetch(input logic [31:0] addr, output bit mis);
        mis = ALIGN_CHECK && (addr[1:0] != 2'b00);
        if (mis) exp_align_err = 1'b1;
        exp_if_q.push_back(mis ? 32'd0 : ref_mem[addr[9:2]]);
    endtask

    // ---------------- scoreboard ----------------
    logic [31:0] mon_exp;
    always @(negedge clock) begin
        if (mc_if_valid) begin
            if (exp_if_q.size() == 0) begin
                check("if_unexpected_valid", 32'd1, 32'd0);
            end else begin
                mon_exp = exp_if_q.pop_front();
                check("if_data", mc_if_data, mon_exp);
            end
        end
        if (mc_mem_valid) begin
            if (exp_mem_q.size() == 0) begin
                check("mem_unexpected_valid", 32'd1, 32'd0);
            end else begin
                mon_exp = exp_mem_q.pop_front();
                check("mem_data", mc_mem_data, mon_exp);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // One transaction: optional fetch and/or memory access raised together.
    // Completion timing: alone -> cycle 3; together -> memory cycle 3, fetch cycle 5.
    task automatic run_txn(input string tag, input bit do_if, input logic [31:0] if_addr,
                           input bit do_mem, input bit rw, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] lanes);
        int exp_if_cyc;
        int exp_mem_cyc;
        int exp_cmds;
        int cmds0;
        bit if_mis;
        bit mem_mis;
        bit exp_stall;
        exp_mem_cyc = do_mem ? 3 : -1;
        exp_if_cyc  = do_if ? (do_mem ? 5 : 3) : -1;
        if_mis  = 1'b0;
        mem_mis = 1'b0;
        if (do_mem) model_mem(rw, addr, wdata, lanes, mem_mis);
        if (do_if)  model_fetch(if_addr, if_mis);
        exp_cmds = ((do_mem && !mem_mis) ? 1 : 0) + ((do_if && !if_mis) ? 1 : 0);

        @(posedge clock); #1;
        cmds0        = ram_cmds;
        if_mc_en     = do_if;
        if_mc_addr   = if_addr;
        mem_mc_en    = do_mem;
        mem_mc_rw    = rw;
        mem_mc_addr  = addr;
        mem_mc_wdata = wdata;
        {mem_mc_en1h, mem_mc_en1l, mem_mc_en2h, mem_mc_en2l} = lanes;

        for (int c = 0; c < 7; c++) begin
            @(negedge clock);
            exp_stall = (do_mem && c < exp_mem_cyc) || (do_if && c < exp_if_cyc);
            check({tag, "_stall"},     32'(mc_stall),     32'(exp_stall));
            check({tag, "_if_valid"},  32'(mc_if_valid),  32'(c == exp_if_cyc));
            check({tag, "_mem_valid"}, 32'(mc_mem_valid), 32'(c == exp_mem_cyc));
            @(posedge clock); #1;
            if (c == exp_if_cyc)  if_mc_en  = 1'b0;
            if (c == exp_mem_cyc) mem_mc_en = 1'b0;
        end
        check({tag, "_ram_cmds"},  32'(ram_cmds - cmds0), 32'(exp_cmds));
        check({tag, "_align_err"}, 32'(mc_align_err),     32'(exp_align_err));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ram_addr"},  ram_addr,              32'd0);
        check({tag, "_ram_rw"},    32'(ram_rw),           32'd0);
        check({tag, "_ram_en"},    32'(ram_en),           32'd0);
        check({tag, "_ram_wdata"}, ram_wdata,             32'd0);
        check({tag, "_if_data"},   mc_if_data,            32'd0);
        check({tag, "_mem_data"},  mc_mem_data,           32'd0);
        check({tag, "_if_valid"},  32'(mc_if_valid),      32'd0);
        check({tag, "_mem_valid"}, 32'(mc_mem_valid),     32'd0);
        check({tag, "_align_err"}, 32'(mc_align_err),     32'd0);
    endtask

    // Write aborted by reset while its command is in CMD
    task automatic reset_mid_write(input logic [31:0] addr);
        int cmds0;
        @(posedge clock); #1;
        cmds0        = ram_cmds;
        mem_mc_en    = 1'b1;
        mem_mc_rw    = 1'b1;
        mem_mc_addr  = addr;
        mem_mc_wdata = 32'hCAFEF00D;
        {mem_mc_en1h, mem_mc_en1l, mem_mc_en2h, mem_mc_en2l} = 4'hF;
        @(posedge clock); #1;
        reset     = 1'b1;
        mem_mc_en = 1'b0;
        #1;
        check("abort_async_ram_en", 32'(ram_en), 32'd0);
        repeat (2) @(negedge clock);
        check_reset_outputs("abort");
        check("abort_ram_cmds", 32'(ram_cmds - cmds0), 32'd0);
        reset = 1'b0;
        last_mem_data = '0;
        exp_align_err = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int kind;
        int mem_idx;
        int if_idx;
        logic [3:0] lanes;
        logic [31:0] maddr;
        logic [31:0] faddr;

        for (int i = 0; i < 256; i++) begin
            ram[i]     = $urandom;
            ref_mem[i] = ram[i];
        end
        ram[2]     = 32'h20080005;
        ref_mem[2] = 32'h20080005;

        repeat (3) @(negedge clock);
        check_reset_outputs("reset");
        check("reset_stall", 32'(mc_stall), 32'd0);
        reset = 1'b0;

        // Isolated fetch
        run_txn("fetch8", 1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

        // Full-word write then read back
        run_txn("wr_dead", 1'b0, 32'h0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        run_txn("rd_dead", 1'b0, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF);

        // Byte write on lane 2l, full read, lane-1h-only read
        run_txn("wr_base", 1'b0, 32'h0, 1'b1, 1'b1, 32'h10, 32'h11223344, 4'hF);
        run_txn("wr_byte", 1'b0, 32'h0, 1'b1, 1'b1, 32'h13, 32'h000000AB, 4'b0001);
        run_txn("rd_word", 1'b0, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
        run_txn("rd_1h",   1'b0, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0, 4'b1000);

        // Fetch and memory read raised together
        run_txn("pair", 1'b1, 32'h8, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF);

        // Reset during CMD of a write, then confirm the word is unchanged
        reset_mid_write(32'h20);
        run_txn("after_abort", 1'b0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, 4'hF);

        // Misaligned fetch, then an aligned access with the flag still sticky
        run_txn("fetch6", 1'b1, 32'h6, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        run_txn("post_mis", 1'b0, 32'h0, 1'b1, 1'b0, 32'h8, 32'h0, 4'hF);

        // Randomized mix of fetch-only, memory-only and simultaneous requests
        for (int t = 0; t < 80; t++) begin
            kind    = $urandom_range(0, 2);
            mem_idx = $urandom_range(64, 79);
            if_idx  = $urandom_range(64, 79);
            lanes   = 4'($urandom_range(1, 15));
            if ($urandom_range(0, 2) == 0) lanes = 4'hF;
            maddr = 32'(mem_idx * 4 + $urandom_range(0, 3));
            if (kind == 2 && if_idx == mem_idx) if_idx = mem_idx ^ 1;
            faddr = 32'(if_idx * 4 + (($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0));
            run_txn("rand", kind != 1, faddr, kind != 0, 1'($urandom_range(0, 1)),
                    maddr, $urandom, lanes);
        end

        // Sticky flag clears only on reset
        @(posedge clock); #1;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check("final_align_err", 32'(mc_align_err), 32'd0);
        reset = 1'b0;

        check("if_queue_drained",  32'(exp_if_q.size()),  32'd0);
        check("mem_queue_drained", 32'(exp_mem_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
